fir_seq_ctrl: RTL
=================

# fir_seq_ctrl

Job-level sequencer for the FIR accelerator. On each `start_i` it:
- clears the datapath;
- requests the tap load into the tap buffer and waits until the buffer is full;
- launches the x source and y sink streams;
- counts stream handshakes until the job's outputs are written back.

It sits between the register-file/event logic of the controller and the streamer/datapath/tap-buffer control inputs. It replaces ad-hoc sequencing with one Moore FSM and counters.

## Interface
Parameters:
- `NB_TAPS`, 50, filter length; must be ≥1.
- `LEN_WIDTH`, 16, width of sample/output counters and `n_samples_i`.

Ports:
- `clk_i`  in  1  single clock; all state on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `clear_i`  in  1  synchronous soft clear, same effect as `rst_i`.
- `start_i`  in  1  job start pulse; sampled only in IDLE.
- `n_samples_i`  in  LEN_WIDTH  number of x samples in the job; latched on accepted start.
- `tap_buffer_full_i`  in  1  tap buffer holds all NB_TAPS taps.
- `y_sink_done_i`  in  1  y sink has committed its last TCDM write.
- `x_valid_i`, `x_ready_i`  in  1 each  x stream handshake, observed only.
- `y_valid_i`, `y_ready_i`  in  1 each  y stream handshake, observed only.
- `dp_clear_o`  out  1  clears datapath delay line and accumulator.
- `h_req_start_o`  out  1  one-cycle start request to h source.
- `xy_req_start_o`  out  1  one-cycle start request to x source and y sink.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle job-end event.
- `err_o`  out  1  sticky error; cleared only by an accepted start, `clear_i` or `rst_i`.
- `y_count_o`  out  LEN_WIDTH  outputs accepted so far in the current job.

## Operation
FSM states: IDLE, CLEAR, REQ_H, WAIT_H, REQ_XY, STREAM, WAIT_SINK, DONE. All outputs are Moore-decoded from registered state and counters.

- IDLE → CLEAR on `start_i`:
  - latch `n_samples_i`;
  - compute `n_out = n_samples − NB_TAPS + 1` at LEN_WIDTH+1 bits;
  - zero `x_cnt` and `y_cnt`;
  - clear `err_o`.
- Short job: if `n_samples_i` < NB_TAPS (including 0), go IDLE → DONE directly and set `err_o`. No stream request is issued.
- CLEAR (1 cycle): `dp_clear_o`=1 → REQ_H.
- REQ_H (1 cycle): `h_req_start_o`=1 → WAIT_H.
- WAIT_H: stay until `tap_buffer_full_i`=1 → REQ_XY.
- REQ_XY (1 cycle): `xy_req_start_o`=1 → STREAM.
- STREAM:
  - `x_cnt` increments on each x handshake (`x_valid_i` & `x_ready_i`) while `x_cnt` < n_samples;
  - `y_cnt` increments on each y handshake;
  - leave to WAIT_SINK on the cycle a y handshake makes `y_cnt` equal `n_out`.
- WAIT_SINK: stay until `y_sink_done_i`=1 → DONE.
- DONE (1 cycle): `done_o`=1 → IDLE.
- Protocol errors set `err_o` but do not change sequencing:
  - an x handshake while `x_cnt` == n_samples;
  - a y handshake in any state other than STREAM.
- `y_count_o` = `y_cnt`. It holds after DONE until the next accepted start.
- `start_i` outside IDLE is ignored.
- `clear_i`/`rst_i` in any state: next state IDLE, counters and `err_o` zeroed, no `done_o`. They take priority over `start_i` and every other transition.

## Timing
- Reset values: state IDLE; all outputs 0; `y_count_o`=0.
- Start accepted at edge *t* gives:
  - `busy_o` and `dp_clear_o` high in cycle t+1;
  - `h_req_start_o` in t+2;
  - earliest `xy_req_start_o` in t+4, when `tap_buffer_full_i` is already 1 in t+3.
- Last y handshake in cycle *c* → WAIT_SINK at c+1.
- With `y_sink_done_i` high at c+1 → `done_o` at c+2 and IDLE/`busy_o`=0 at c+3.
- Short-job path: `done_o` at t+1, `busy_o`=1 only in that cycle.
- Counters do not wrap. `n_samples` up to 2^LEN_WIDTH−1 is supported.

## Test plan
- NB_TAPS=4, n_samples=10, ideal streams → 7 y handshakes, `y_count_o`=7, exactly one `done_o`, `err_o`=0, one pulse each of `h_req_start_o` and `xy_req_start_o`.
- `tap_buffer_full_i` delayed 20 cycles → `xy_req_start_o` exactly 1 cycle after it rises; no x/y counting before that.
- n_samples=3 with NB_TAPS=4 → `done_o` 1 cycle after start, `err_o`=1, no request pulses.
- `clear_i` asserted mid-STREAM at `y_cnt`=3 → IDLE next cycle, `y_count_o`=0, no `done_o`; the next start runs normally.
- An 11th x handshake injected with n_samples=10 → `err_o`=1, job still completes with `done_o`.
- `start_i` held high for the whole job → exactly one job, then an immediate restart from IDLE.

Source files
------------

// File: rtl/fir_seq_ctrl.sv
// Job-level sequencer for the FIR accelerator: clears the datapath, loads taps,
// launches the x/y streams and counts handshakes until write-back completes.
module fir_seq_ctrl #(
  parameter int unsigned NB_TAPS   = 50,
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] n_samples_i,
  input  logic                 tap_buffer_full_i,
  input  logic                 y_sink_done_i,
  input  logic                 x_valid_i,
  input  logic                 x_ready_i,
  input  logic                 y_valid_i,
  input  logic                 y_ready_i,
  output logic                 dp_clear_o,
  output logic                 h_req_start_o,
  output logic                 xy_req_start_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [LEN_WIDTH-1:0] y_count_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_REQ_H, S_WAIT_H, S_REQ_XY, S_STREAM, S_WAIT_SINK, S_DONE
  } state_t;

  localparam logic [LEN_WIDTH:0]   TAPS_W = (LEN_WIDTH+1)'(NB_TAPS);
  localparam logic [LEN_WIDTH:0]   ONE_W  = (LEN_WIDTH+1)'(1);
  localparam logic [LEN_WIDTH-1:0] ONE_N  = LEN_WIDTH'(1);

  state_t               r_state;
  state_t               w_next;
  logic [LEN_WIDTH-1:0] r_n_samples;
  logic [LEN_WIDTH:0]   r_n_out;
  logic [LEN_WIDTH-1:0] r_x_cnt;
  logic [LEN_WIDTH-1:0] r_y_cnt;
  logic                 r_err;

  logic [LEN_WIDTH:0] w_n_ext;
  logic               w_short;
  logic               w_start;
  logic               w_x_hs;
  logic               w_y_hs;
  logic               w_x_full;
  logic               w_y_last;

  assign w_n_ext  = {1'b0, n_samples_i};
  assign w_short  = (w_n_ext < TAPS_W);
  assign w_start  = (r_state == S_IDLE) && start_i;
  assign w_x_hs   = x_valid_i & x_ready_i;
  assign w_y_hs   = y_valid_i & y_ready_i;
  assign w_x_full = (r_x_cnt == r_n_samples);
  // Compare against the post-increment count so the exit happens on the last handshake
  assign w_y_last = w_y_hs && (({1'b0, r_y_cnt} + ONE_W) == r_n_out);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (start_i) w_next = w_short ? S_DONE : S_CLEAR;
      S_CLEAR:     w_next = S_REQ_H;
      S_REQ_H:     w_next = S_WAIT_H;
      S_WAIT_H:    if (tap_buffer_full_i) w_next = S_REQ_XY;
      S_REQ_XY:    w_next = S_STREAM;
      S_STREAM:    if (w_y_last) w_next = S_WAIT_SINK;
      S_WAIT_SINK: if (y_sink_done_i) w_next = S_DONE;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_state     <= S_IDLE;
      r_n_samples <= '0;
      r_n_out     <= '0;
      r_x_cnt     <= '0;
      r_y_cnt     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_n_samples <= n_samples_i;
        r_n_out     <= w_n_ext - TAPS_W + ONE_W;
        r_x_cnt     <= '0;
        r_y_cnt     <= '0;
        r_err       <= w_short;
      end else if (r_state == S_STREAM) begin
        if (w_x_hs) begin
          if (w_x_full) r_err   <= 1'b1;
          else          r_x_cnt <= r_x_cnt + ONE_N;
        end
        if (w_y_hs) r_y_cnt <= r_y_cnt + ONE_N;
      end else if (w_y_hs) begin
        r_err <= 1'b1;
      end
    end
  end

  assign dp_clear_o     = (r_state == S_CLEAR);
  assign h_req_start_o  = (r_state == S_REQ_H);
  assign xy_req_start_o = (r_state == S_REQ_XY);
  assign busy_o         = (r_state != S_IDLE);
  assign done_o         = (r_state == S_DONE);
  assign err_o          = r_err;
  assign y_count_o      = r_y_cnt;

endmodule
